// File: rtl/snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snn_timestep_scheduler
// Description : Timestep tick generator plus per-timestep layer start/done
//               sequencer. Optional layer watchdog: SNN_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_timestep_scheduler #(
    parameter int NUM_LAYERS     = 4,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 4,
    parameter int WDT_CYCLES     = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_valid,
    input  logic [CNT_W-1:0]      cfg_period,
    output logic                  cfg_ready,
    output logic                  tick,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic [31:0]           timestep_cnt,
    output logic                  overrun,
    input  logic                  overrun_clr
`ifdef SNN_SCHED_WATCHDOG_EN
    ,
    output logic                  wdt_timeout
`endif
);

    localparam int                 c_IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0]   c_MIN_PERIOD = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     r_phase;
    logic [CNT_W-1:0]     w_peff;
    logic [c_IDX_W-1:0]   w_next_idx;
    logic                 w_cfg_fire;
    logic                 w_busy_st;

    assign w_peff     = (r_period < c_MIN_PERIOD) ? c_MIN_PERIOD : r_period;
    assign w_next_idx = r_idx + c_IDX_W'(1);
    assign w_busy_st  = (r_state == START) || (r_state == WAIT);
    assign busy       = w_busy_st;
    assign cfg_ready  = ((r_state == IDLE) || (r_state == ARMED)) && !tick;
    assign w_cfg_fire = cfg_valid && cfg_ready;

    // A period update restarts the phase so the new period applies from acceptance.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= CNT_W'(DEFAULT_PERIOD);
            r_phase  <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (w_cfg_fire) begin
                r_period <= cfg_period;
                r_phase  <= '0;
            end else if (!enable) begin
                r_phase <= '0;
            end else if (r_phase == (w_peff - CNT_W'(1))) begin
                r_phase <= '0;
                tick    <= 1'b1;
            end else begin
                r_phase <= r_phase + CNT_W'(1);
            end
        end
    end

`ifdef SNN_SCHED_WATCHDOG_EN
    localparam int c_WDT_W = $clog2(WDT_CYCLES + 1);
    logic [c_WDT_W-1:0] r_wdt;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = (WDT_CYCLES != 0);
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            layer_start  <= '0;
            timestep_cnt <= '0;
            overrun      <= 1'b0;
`ifdef SNN_SCHED_WATCHDOG_EN
            r_wdt        <= '0;
            wdt_timeout  <= 1'b0;
`endif
        end else begin
            layer_start <= '0;

            // Ticks landing mid-sequence are dropped; the flag set beats the clear.
            if (tick && w_busy_st) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
`ifdef SNN_SCHED_WATCHDOG_EN
            if (overrun_clr) begin
                wdt_timeout <= 1'b0;
            end
`endif

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        r_idx       <= '0;
                        layer_start <= NUM_LAYERS'(1);
                        r_state     <= START;
`ifdef SNN_SCHED_WATCHDOG_EN
                        r_wdt       <= '0;
`endif
                    end else if (!enable) begin
                        r_state <= IDLE;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (layer_done[r_idx]) begin
                        if (r_idx == c_LAST_IDX) begin
                            timestep_cnt <= timestep_cnt + 32'd1;
                            r_state      <= enable ? ARMED : IDLE;
                        end else begin
                            r_idx       <= w_next_idx;
                            layer_start <= NUM_LAYERS'(1) << w_next_idx;
                            r_state     <= START;
`ifdef SNN_SCHED_WATCHDOG_EN
                            r_wdt       <= '0;
`endif
                        end
                    end
`ifdef SNN_SCHED_WATCHDOG_EN
                    else if (r_wdt == c_WDT_W'(WDT_CYCLES - 1)) begin
                        wdt_timeout <= 1'b1;
                        r_state     <= ARMED;
                    end else begin
                        r_wdt <= r_wdt + c_WDT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_timestep_scheduler
// Description : Scoreboard bench: expected tick/layer_start events are queued
//               per scenario and popped by a monitor as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_timestep_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_period = '0;
    logic        cfg_ready;
    logic        tick;
    logic [3:0]  layer_start;
    logic [3:0]  layer_done;
    logic        busy;
    logic [31:0] timestep_cnt;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef SNN_SCHED_WATCHDOG_EN
    logic        wdt_timeout;
`endif

    logic [3:0]  resp_done  = '0;
    logic [3:0]  extra_done = '0;
    assign layer_done = resp_done | extra_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dly [4];
    int due [4];

    typedef struct {
        int         c;
        logic       tk;
        logic [3:0] ls;
    } ev_t;
    ev_t exp_q [$];
    ev_t mon_e;

    snn_timestep_scheduler #(
        .NUM_LAYERS     (4),
        .CNT_W          (16),
        .DEFAULT_PERIOD (4),
`ifdef SNN_SCHED_WATCHDOG_EN
        .WDT_CYCLES     (16)
`else
        .WDT_CYCLES     (1024)
`endif
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_ready    (cfg_ready),
        .tick         (tick),
        .layer_start  (layer_start),
        .layer_done   (layer_done),
        .busy         (busy),
        .timestep_cnt (timestep_cnt),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
`ifdef SNN_SCHED_WATCHDOG_EN
        ,
        .wdt_timeout  (wdt_timeout)
`endif
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Layer model: pulse layer_done[i] dly[i] cycles after its start (0 = never).
    initial begin
        for (int i = 0; i < 4; i++) due[i] = -1;
        forever begin
            @(posedge clk_in);
            #1;
            for (int i = 0; i < 4; i++) resp_done[i] = rst_n && (due[i] == cyc);
            @(negedge clk_in);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) due[i] = -1;
                else if (layer_start[i] && dly[i] != 0) due[i] = cyc + dly[i];
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_n && (tick || layer_start != 4'b0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event: got tick=%0b layer_start=%b at cycle %0d, required no event",
                         tick, layer_start, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.c != cyc || mon_e.tk != tick || mon_e.ls != layer_start) begin
                    errors++;
                    $display("FAIL event: got cycle %0d tick=%0b layer_start=%b, required cycle %0d tick=%0b layer_start=%b",
                             cyc, tick, layer_start, mon_e.c, mon_e.tk, mon_e.ls);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void ex(input int c, input logic t, input logic [3:0] l);
        exp_q.push_back('{c, t, l});
    endfunction

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset(input int d0, input int d1, input int d2, input int d3);
        rst_n = 1'b0;
        enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0;
        overrun_clr = 1'b0; extra_done = '0;
        exp_q.delete();
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Default P=4, every layer answers 1 cycle after its start.
        do_reset(1, 1, 1, 1);
        chk("rst_tick", {31'b0, tick}, 32'd0);
        chk("rst_layer_start", {28'b0, layer_start}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_timestep_cnt", timestep_cnt, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        ex(6, 1, 4'b0000); ex(7, 0, 4'b0001); ex(9, 0, 4'b0010);
        ex(10, 1, 4'b0000); ex(11, 0, 4'b0100); ex(13, 0, 4'b1000);
        ex(14, 1, 4'b0000);
        at_cycle(2);  enable = 1'b1;
        at_cycle(6);  chk("cfg_ready_on_tick", {31'b0, cfg_ready}, 32'd0);
        at_cycle(8);  chk("busy_in_wait", {31'b0, busy}, 32'd1);
        at_cycle(11); chk("overrun_set", {31'b0, overrun}, 32'd1);
        at_cycle(16);
        chk("ts_cnt_after_seq", timestep_cnt, 32'd1);
        chk("busy_armed", {31'b0, busy}, 32'd0);
        chk("cfg_ready_armed", {31'b0, cfg_ready}, 32'd1);
        overrun_clr = 1'b1;
        at_cycle(17);
        overrun_clr = 1'b0;
        chk("overrun_cleared", {31'b0, overrun}, 32'd0);
        chk("s1_queue_empty", exp_q.size(), 32'd0);

        // Period 1 clamps to 2; later period 10 offered while busy, accepted in ARMED.
        do_reset(1, 1, 1, 1);
        ex(4, 1, 4'b0000); ex(5, 0, 4'b0001); ex(6, 1, 4'b0000); ex(7, 0, 4'b0010);
        ex(8, 1, 4'b0000); ex(9, 0, 4'b0100); ex(10, 1, 4'b0000); ex(11, 0, 4'b1000);
        ex(12, 1, 4'b0000); ex(24, 1, 4'b0000); ex(25, 0, 4'b0001);
        at_cycle(1);
        cfg_valid = 1'b1; cfg_period = 16'd1;
        chk("cfg_ready_idle", {31'b0, cfg_ready}, 32'd1);
        at_cycle(2);  cfg_valid = 1'b0; enable = 1'b1;
        at_cycle(7);  overrun_clr = 1'b1;
        at_cycle(8);  chk("overrun_clr_alone", {31'b0, overrun}, 32'd0);
        at_cycle(9);
        overrun_clr = 1'b0;
        chk("overrun_set_wins", {31'b0, overrun}, 32'd1);
        cfg_valid = 1'b1; cfg_period = 16'd10;
        chk("cfg_ready_busy", {31'b0, cfg_ready}, 32'd0);
        at_cycle(13);
        chk("cfg_ready_armed2", {31'b0, cfg_ready}, 32'd1);
        chk("ts_cnt_p2", timestep_cnt, 32'd1);
        at_cycle(14); cfg_valid = 1'b0;
        at_cycle(26); chk("s2_queue_empty", exp_q.size(), 32'd0);

        // Spurious done[3] while waiting on layer 0; enable drops while waiting on layer 1.
        do_reset(4, 5, 1, 1);
        ex(6, 1, 4'b0000); ex(7, 0, 4'b0001); ex(10, 1, 4'b0000);
        ex(12, 0, 4'b0010); ex(14, 1, 4'b0000); ex(18, 0, 4'b0100); ex(20, 0, 4'b1000);
        at_cycle(2);  enable = 1'b1;
        at_cycle(9);  extra_done = 4'b1000;
        at_cycle(10); extra_done = 4'b0000;
        at_cycle(14); enable = 1'b0;
        at_cycle(30);
        chk("ts_cnt_after_disable", timestep_cnt, 32'd1);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("cfg_ready_idle2", {31'b0, cfg_ready}, 32'd1);
        chk("s3_queue_empty", exp_q.size(), 32'd0);

`ifdef SNN_SCHED_WATCHDOG_EN
        // Layer 1 never answers: abort after 16 WAIT cycles, next tick restarts layer 0.
        do_reset(1, 0, 1, 1);
        ex(6, 1, 4'b0000); ex(7, 0, 4'b0001); ex(9, 0, 4'b0010);
        ex(10, 1, 4'b0000); ex(14, 1, 4'b0000); ex(18, 1, 4'b0000);
        ex(22, 1, 4'b0000); ex(26, 1, 4'b0000); ex(27, 0, 4'b0001);
        at_cycle(2);  enable = 1'b1;
        at_cycle(25); chk("wdt_not_yet", {31'b0, wdt_timeout}, 32'd0);
        at_cycle(26);
        chk("wdt_fired", {31'b0, wdt_timeout}, 32'd1);
        chk("ts_cnt_wdt", timestep_cnt, 32'd0);
        at_cycle(28); chk("sw_queue_empty", exp_q.size(), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
